// File: rtl/seq_mult_param_if.sv
// Request/result bundle for the sequential multiplier: level start in, registered
// product with valid/busy status out.
interface seq_mult_param_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 tc;
    logic [WIDTH-1:0]     mlier;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prodt;
    logic                 valid;
    logic                 busy;

    modport master (
        output start, tc, mlier, mcand,
        input  prodt, valid, busy
    );

    modport slave (
        input  start, tc, mlier, mcand,
        output prodt, valid, busy
    );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier: one multiplier bit per clock, optional
// two's-complement operands via sign/magnitude, optional early exit.
module seq_mult_param #(
    parameter int WIDTH      = 32,
    parameter int SIGNED_EN  = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    seq_mult_param_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] mult_reg;
    logic [PW-1:0]    mcand_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    prodt_reg;
    logic [CW-1:0]    count_reg;
    logic             neg_reg;
    logic             valid_reg;
    logic             busy_reg;

    logic             is_signed;
    logic [WIDTH-1:0] mlier_mag;
    logic [WIDTH-1:0] mcand_mag;
    logic [WIDTH-1:0] mult_shift;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    acc_final;
    logic             last_iter;

    always_comb begin
        is_signed  = (SIGNED_EN != 0) && bus.tc;
        mlier_mag  = (is_signed && bus.mlier[WIDTH-1]) ? (~bus.mlier + 1'b1) : bus.mlier;
        mcand_mag  = (is_signed && bus.mcand[WIDTH-1]) ? (~bus.mcand + 1'b1) : bus.mcand;
        // mcand_reg is pre-shifted each iteration, so it always equals mcand << count
        acc_next   = mult_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        mult_shift = mult_reg >> 1;
        last_iter  = (count_reg == CW'(WIDTH - 1)) ||
                     ((EARLY_EXIT != 0) && (mult_shift == '0));
        acc_final  = neg_reg ? (~acc_next + 1'b1) : acc_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            mult_reg  <= '0;
            mcand_reg <= '0;
            acc_reg   <= '0;
            prodt_reg <= '0;
            count_reg <= '0;
            neg_reg   <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mult_reg  <= mlier_mag;
                        mcand_reg <= {{WIDTH{1'b0}}, mcand_mag};
                        neg_reg   <= is_signed && (bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1]);
                        acc_reg   <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    mult_reg  <= mult_shift;
                    mcand_reg <= mcand_reg << 1;
                    count_reg <= count_reg + CW'(1);
                    if (last_iter) begin
                        prodt_reg <= acc_final;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.prodt = prodt_reg;
    assign bus.valid = valid_reg;
    assign bus.busy  = busy_reg;
endmodule
